// File: rtl/dsp_acc.sv
// ---------------------------------------------------------------------------
// dsp_acc -- frame accumulator for the product stream of an (a+b)*c stage.
//
// Sums frames of (frame_len+1) signed samples and presents each frame sum on
// a valid/ready output with a one-cycle result latency.
//
// Parameters
//   DW        operand width of the upstream multiply; sample width is 2*DW
//   AW        frame-length field width; frames are 1..2^AW samples long
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   s_tdata     signed product sample (2*DW bits)
//   s_tvalid    s_tdata valid
//   s_tready    block can accept a sample
//   frame_len   frame length minus one, sampled at the first sample of a frame
//   m_tdata     signed frame sum (2*DW bits)
//   m_tvalid    m_tdata valid
//   m_tready    downstream accepts m_tdata
//   m_ovf       frame sum did not fit in 2*DW bits (qualified by m_tvalid)
//
// Configuration
//   DSP_ACC_SAT_EN  defined:   m_tdata saturates to the signed 2*DW range
//                   undefined: m_tdata is the low 2*DW bits of the sum (wrap)
// ---------------------------------------------------------------------------
module dsp_acc #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [2*DW-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [AW-1:0]        frame_len,
    output logic signed [2*DW-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_ovf
);

    localparam int SW  = 2 * DW;   // sample / output width
    localparam int ACW = SW + AW;  // accumulator width: 2^AW full-scale samples never overflow

    typedef enum logic {
        IDLE  = 1'b0,  // no partial frame held
        ACCUM = 1'b1   // partial frame held in acc
    } state_t;

    state_t                 state, state_nxt;
    logic signed [ACW-1:0]  acc, acc_nxt;
    logic [AW-1:0]          cnt, cnt_nxt;
    logic [AW-1:0]          len, len_nxt;

    logic                   accept;
    logic                   frame_done;
    logic signed [ACW-1:0]  sample_ext;
    logic signed [ACW-1:0]  sum;
    logic [AW:0]            sum_top;
    logic                   sum_ovf;
    logic signed [SW-1:0]   sum_out;

    // The output register frees up in the same edge it is consumed, so a new
    // sample may be taken while the old result is being handed off.
    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;

    assign sample_ext = {{AW{s_tdata[SW-1]}}, s_tdata};

    // acc is kept at zero whenever the FSM is in IDLE, so the same adder
    // serves both the first sample of a frame and every later one.
    assign sum = acc + sample_ext;

    // The sum fits in SW signed bits exactly when the bits from the SW sign
    // position upward are all equal.
    assign sum_top = sum[ACW-1:SW-1];
    assign sum_ovf = !((&sum_top) || !(|sum_top));

`ifdef DSP_ACC_SAT_EN
    always_comb begin
        if (sum_ovf)
            sum_out = sum[ACW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        else
            sum_out = sum[SW-1:0];
    end
`else
    assign sum_out = sum[SW-1:0];
`endif

    // Next-state logic. frame_len is captured only on the first accepted
    // sample of a frame; later changes do not affect the frame in flight.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        len_nxt    = len;
        frame_done = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    len_nxt = frame_len;
                    if (frame_len == '0) begin
                        frame_done = 1'b1;
                    end else begin
                        acc_nxt   = sum;
                        cnt_nxt   = AW'(1);
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt == len) begin
                        frame_done = 1'b1;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + AW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len   <= len_nxt;
        end
    end

    // Output register: a completing frame always wins, which also covers the
    // consume-and-reload edge without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_ovf    <= 1'b0;
        end else if (frame_done) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sum_out;
            m_ovf    <= sum_ovf;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_acc.sv
// ---------------------------------------------------------------------------
// tb_dsp_acc -- self-checking bench for dsp_acc (DW=8, AW=4).
// Expected frame results are pushed to a scoreboard queue as stimulus is
// driven and popped by a negedge monitor whenever the DUT hands off a result.
// ---------------------------------------------------------------------------
module tb_dsp_acc;

    logic               clk;
    logic               rst;
    logic signed [15:0] s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic [3:0]         frame_len;
    logic signed [15:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_ovf;

    typedef struct {
        logic [15:0] d;
        logic        o;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic chk_ready = 1'b0;

    dsp_acc #(.DW(8), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .frame_len (frame_len),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_ovf     (m_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result for a full-precision frame sum.
    function automatic exp_t mk(input int sum, input string name);
        exp_t e;
        logic [31:0] s32;
        s32    = sum;
        e.o    = (sum > 32767) || (sum < -32768);
`ifdef DSP_ACC_SAT_EN
        if (sum > 32767)       e.d = 16'h7FFF;
        else if (sum < -32768) e.d = 16'h8000;
        else                   e.d = s32[15:0];
`else
        e.d    = s32[15:0];
`endif
        e.name = name;
        return e;
    endfunction

    // Scoreboard monitor and constant-ready watcher, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && chk_ready) begin
            total++;
            if (s_tready !== 1'b1) begin
                bad++;
                $display("FAIL ready_const: s_tready=%b expected 1", s_tready);
            end
        end
        if (!rst && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: m_tdata=%0d with empty scoreboard", m_tdata);
            end else begin
                e = sb.pop_front();
                if (m_tdata !== e.d || m_ovf !== e.o) begin
                    bad++;
                    $display("FAIL %s: got data=%0d ovf=%b expected data=%0d ovf=%b",
                             e.name, m_tdata, m_ovf, $signed(e.d), e.o);
                end
            end
        end
    end

    // Offer one sample and return #1 after the edge on which it was accepted.
    task automatic send(input int d, input logic [3:0] fl);
        int waited;
        logic [31:0] d32;
        waited    = 0;
        d32       = d;
        s_tdata   = d32[15:0];
        frame_len = fl;
        s_tvalid  = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: s_tready stuck at %b for sample %0d", s_tready, d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_bit("rst_m_tvalid", m_tvalid, 1'b0);
        expect_bit("rst_m_ovf", m_ovf, 1'b0);
        expect_bit("rst_s_tready", s_tready, 1'b1);
        total++;
        if (m_tdata !== 16'sd0) begin
            bad++;
            $display("FAIL rst_m_tdata: got %0d expected 0", m_tdata);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_bit("post_rst_s_tready", s_tready, 1'b1);
    endtask

    task automatic test_frame();
        send(100, 4'd3);
        send(200, 4'd3);
        send(-50, 4'd3);
        expect_bit("frame_no_early_valid", m_tvalid, 1'b0);
        sb.push_back(mk(260, "frame_sum_260"));
        send(10, 4'd3);
        expect_bit("frame_latency", m_tvalid, 1'b1);
        @(posedge clk);
        #1;
        expect_bit("frame_valid_clears", m_tvalid, 1'b0);
    endtask

    task automatic test_len0();
        int vals[3] = '{5, -7, 9};
        chk_ready = 1'b1;
        foreach (vals[i]) begin
            sb.push_back(mk(vals[i], "len0_out"));
            send(vals[i], 4'd0);
            expect_bit("len0_valid", m_tvalid, 1'b1);
            total++;
            if (m_tdata !== 16'(vals[i])) begin
                bad++;
                $display("FAIL len0_data: got %0d expected %0d", m_tdata, vals[i]);
            end
        end
        chk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        m_tready = 1'b0;
        send(1, 4'd1);
        sb.push_back(mk(3, "bp_first_frame"));
        send(2, 4'd1);
        fork
            send(4, 4'd1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    expect_bit("bp_hold_valid", m_tvalid, 1'b1);
                    expect_bit("bp_s_tready", s_tready, 1'b0);
                    total++;
                    if (m_tdata !== 16'sd3) begin
                        bad++;
                        $display("FAIL bp_hold_data: got %0d expected 3", m_tdata);
                    end
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        sb.push_back(mk(9, "bp_second_frame"));
        send(5, 4'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int pa[6] = '{30000, -30000, 32767, -32768, 16384, -16384};
        int pb[6] = '{30000, -30000, 0,     0,      16384, -16385};
        foreach (pa[i]) begin
            send(pa[i], 4'd1);
            sb.push_back(mk(pa[i] + pb[i], $sformatf("ovf_pair%0d", i)));
            send(pb[i], 4'd1);
        end
        // Longest frame at both full-scale extremes.
        for (int k = 0; k < 16; k++) begin
            if (k == 15) sb.push_back(mk(-32768 * 16, "max_frame_neg"));
            send(-32768, 4'd15);
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 15) sb.push_back(mk(32767 * 16, "max_frame_pos"));
            send(32767, 4'd15);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        send(7, 4'd3);
        send(8, 4'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_bit("midrst_valid", m_tvalid, 1'b0);
        expect_bit("midrst_s_tready", s_tready, 1'b1);
        rst = 1'b0;
        sb.push_back(mk(42, "midrst_fresh_frame"));
        send(42, 4'd0);
        expect_bit("midrst_out_valid", m_tvalid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_len_change();
        send(1, 4'd3);
        send(2, 4'd0);
        expect_bit("lenchg_no_out2", m_tvalid, 1'b0);
        send(3, 4'd0);
        expect_bit("lenchg_no_out3", m_tvalid, 1'b0);
        sb.push_back(mk(10, "lenchg_sum"));
        send(4, 4'd0);
        expect_bit("lenchg_out4", m_tvalid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        frame_len = '0;
        m_tready  = 1'b1;

        test_reset();
        test_frame();
        test_len0();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        test_len_change();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_acc.md
DSP_ACC -- requirements
Module: dsp_acc

Interface
REQ-001 Parameter DW, default 8: operand width of the upstream (a+b)*c multiply stage; sample width is 2*DW.
REQ-002 Parameter AW, default 4: frame-length field width; frame length range is 1..2^AW samples.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port s_tdata  input  2*DW signed  product sample from the upstream multiply stage.
REQ-006 Port s_tvalid  input  1  s_tdata valid.
REQ-007 Port s_tready  output  1  block can accept a sample.
REQ-008 Port frame_len  input  AW  frame length minus one (0 means 1 sample per frame).
REQ-009 Port m_tdata  output  2*DW signed  frame sum.
REQ-010 Port m_tvalid  output  1  m_tdata valid.
REQ-011 Port m_tready  input  1  downstream accepts m_tdata.
REQ-012 Port m_ovf  output  1  frame sum did not fit in 2*DW bits; qualified by m_tvalid.

Function
REQ-013 A sample SHALL be accepted only in a cycle where s_tvalid and s_tready are both 1.
REQ-014 s_tready SHALL equal (not m_tvalid) or m_tready, combinationally.
REQ-015 The internal accumulator SHALL be 2*DW+AW bits signed, sign-extending each sample, so it never overflows.
REQ-016 The FSM SHALL have two states, IDLE (no partial frame) and ACCUM (partial frame held).
REQ-017 In IDLE, an accepted sample SHALL latch frame_len as the frame length L for the whole frame; frame_len changes mid-frame SHALL be ignored.
REQ-018 IDLE + accept with L=0 SHALL load the output register with that sample and remain in IDLE.
REQ-019 IDLE + accept with L>0 SHALL set the accumulator to the sample, set the count to 1 and go to ACCUM.
REQ-020 ACCUM + accept with count<L SHALL add the sample and increment the count.
REQ-021 ACCUM + accept with count=L (last sample) SHALL load the output register with accumulator+sample, clear the accumulator and count, and go to IDLE.
REQ-022 No accept SHALL leave the accumulator, count and state unchanged.
REQ-023 m_tvalid SHALL rise in the cycle after the last sample of a frame is accepted (latency 1 cycle).
REQ-024 m_tvalid and m_tdata SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-025 When the output is consumed and no new frame completes in the same edge, m_tvalid SHALL clear.
REQ-026 When the output is consumed and a frame completes in the same edge, the output register SHALL load the new sum and m_tvalid SHALL stay 1, giving back-to-back frames with no bubble.
REQ-027 m_ovf SHALL be 1 when the full sum lies outside [-2^(2*DW-1), 2^(2*DW-1)-1], else 0.

Reset
REQ-028 While rst=1, the block SHALL set: state IDLE, accumulator 0, count 0, latched L 0, m_tvalid 0, m_tdata 0, m_ovf 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first sample after reset starts a new frame.
REQ-030 s_tready SHALL be 1 during and immediately after reset (m_tvalid=0).

Configuration
REQ-031 Macro DSP_ACC_SAT_EN defined: m_tdata SHALL be the full sum saturated to the signed 2*DW range (max 2^(2*DW-1)-1, min -2^(2*DW-1)).
REQ-032 Macro DSP_ACC_SAT_EN undefined: m_tdata SHALL be the low 2*DW bits of the full sum (wrap); m_ovf behaviour is unchanged.

Verification (DW=8, AW=4)
REQ-033 frame_len=3; samples 100,200,-50,10 with continuous valid and m_tready=1 -> one output 260, m_ovf=0, m_tvalid high exactly 1 cycle after the 4th accept.
REQ-034 frame_len=0; samples 5,-7,9 back-to-back -> outputs 5,-7,9 on consecutive cycles, s_tready constantly 1.
REQ-035 frame_len=1; hold m_tready=0 after first frame (1,2) completes -> m_tdata=3 held, s_tready=0, no sample lost; release m_tready -> next frame proceeds.
REQ-036 frame_len=1; samples 30000,30000 -> m_ovf=1; with SAT_EN m_tdata=32767; without SAT_EN m_tdata=-5536.
REQ-037 frame_len=3; accept 2 samples, pulse rst 1 cycle, then frame_len=0 and sample 42 -> output 42, no stale partial sum.
REQ-038 frame_len changed from 3 to 0 after the first accept of a frame -> frame still completes after 4 samples.
